// File: rtl/slug_port_pkg.sv
// Shared field positions and FSM encoding for the slug CPU port mailbox.
package slug_port_pkg;

  // cpu_out (CPU port_out) field positions
  localparam int CO_C2H_LO  = 0;
  localparam int CO_C2H_HI  = 4;
  localparam int CO_C2H_REQ = 8;
  localparam int CO_H2C_ACK = 12;

  // cpu_in (CPU port_in) field positions
  localparam int CI_H2C_LO   = 0;
  localparam int CI_H2C_HI   = 4;
  localparam int CI_C2H_ACK  = 8;
  localparam int CI_H2C_REQ  = 12;
  localparam int CI_C2H_FULL = 16;
  localparam int CI_H2C_PEND = 17;

  // h2c presentation FSM; RESYNC only lives for the first cycle after reset
  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    WAIT   = 2'd2
  } h2c_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrap-bit pointers. No bypass in either direction: a pushed
// byte is visible the cycle after the push, and a push into a full FIFO is
// dropped even if a pop happens on the same edge.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  output logic       full,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wp, rp;
  logic        do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

  // Storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

  // Pointer advance; occupancy saturates because push/pop are gated above
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rp <= rp + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/slug_port_mailbox.sv
// Peripheral side of the slug CPU I/O ports. Bytes move between the CPU
// (toggle handshake on port_out/port_in) and a host valid/ready byte stream,
// with one FIFO per direction. Every CPU-visible output comes from a register
// or FIFO pointer, so there is no combinational path from cpu_out to cpu_in.
module slug_port_mailbox
  import slug_port_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_out,
  output logic [31:0] cpu_in,
  output logic [7:0]  c2h_data,
  output logic        c2h_valid,
  input  logic        c2h_ready,
  input  logic [7:0]  h2c_data,
  input  logic        h2c_valid,
  output logic        h2c_ready
);

  h2c_state_t state;
  logic       c2h_ack, h2c_req;
  logic [7:0] present;

  logic       c2h_full, c2h_empty, h2c_full, h2c_empty;
  logic [7:0] c2h_din, h2c_dout;
  logic       c2h_push, h2c_pop, h2c_acked;

  // Only the data nibbles and the two toggles of cpu_out carry meaning
  logic unused_cpu_out;
  assign unused_cpu_out = ^{cpu_out[31:13], cpu_out[11:9]};

  assign c2h_din   = {cpu_out[CO_C2H_HI +: 4], cpu_out[CO_C2H_LO +: 4]};
  assign c2h_push  = (state != RESYNC) && (cpu_out[CO_C2H_REQ] != c2h_ack) && !c2h_full;
  assign h2c_acked = (cpu_out[CO_H2C_ACK] == h2c_req);

  // Pop the next h2c byte when nothing is presented, or the presented one was acked
  always_comb begin
    h2c_pop = 1'b0;
    case (state)
      IDLE:    h2c_pop = !h2c_empty;
      WAIT:    h2c_pop = h2c_acked && !h2c_empty;
      default: h2c_pop = 1'b0;
    endcase
  end

  byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_c2h (
    .clk   (clk),
    .rst   (rst),
    .push  (c2h_push),
    .din   (c2h_din),
    .full  (c2h_full),
    .pop   (c2h_valid && c2h_ready),
    .dout  (c2h_data),
    .empty (c2h_empty)
  );

  byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_h2c (
    .clk   (clk),
    .rst   (rst),
    .push  (h2c_valid),
    .din   (h2c_data),
    .full  (h2c_full),
    .pop   (h2c_pop),
    .dout  (h2c_dout),
    .empty (h2c_empty)
  );

  assign c2h_valid = !c2h_empty;
  assign h2c_ready = !h2c_full;

  // Toggle/ack registers, presented byte and h2c FSM. RESYNC adopts whatever
  // toggles the CPU left behind so stale state never looks like a new event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RESYNC;
      c2h_ack <= 1'b0;
      h2c_req <= 1'b0;
      present <= 8'h00;
    end else if (state == RESYNC) begin
      c2h_ack <= cpu_out[CO_C2H_REQ];
      h2c_req <= cpu_out[CO_H2C_ACK];
      state   <= IDLE;
    end else begin
      if (c2h_push) c2h_ack <= cpu_out[CO_C2H_REQ];
      if (h2c_pop) begin
        present <= h2c_dout;
        h2c_req <= ~h2c_req;
        state   <= WAIT;
      end else if (state == WAIT && h2c_acked) begin
        state   <= IDLE;
      end
    end
  end

  // Assemble port_in; unused bits tie to zero
  always_comb begin
    cpu_in                   = '0;
    cpu_in[CI_H2C_LO +: 4]   = present[3:0];
    cpu_in[CI_H2C_HI +: 4]   = present[7:4];
    cpu_in[CI_C2H_ACK]       = c2h_ack;
    cpu_in[CI_H2C_REQ]       = h2c_req;
    cpu_in[CI_C2H_FULL]      = c2h_full;
    cpu_in[CI_H2C_PEND]      = (state == WAIT);
  end

endmodule

// File: tb/tb_slug_port_mailbox.sv
// Bench for slug_port_mailbox: directed scenarios with literal expectations,
// then randomized CPU/host traffic, all checked every cycle against a
// queue-based model of the mailbox.
module tb_slug_port_mailbox;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_out, cpu_in;
  logic [7:0]  c2h_data, h2c_data;
  logic        c2h_valid, c2h_ready, h2c_valid, h2c_ready;

  int checks = 0;
  int errors = 0;

  slug_port_mailbox #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_out   (cpu_out),
    .cpu_in    (cpu_in),
    .c2h_data  (c2h_data),
    .c2h_valid (c2h_valid),
    .c2h_ready (c2h_ready),
    .h2c_data  (h2c_data),
    .h2c_valid (h2c_valid),
    .h2c_ready (h2c_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] q_c2h[$];
  logic [7:0] q_h2c[$];
  bit         m_resync, m_wait, m_ack, m_req;
  logic [7:0] m_pres;

  always @(posedge clk or posedge rst) begin
    int nc, nh;
    if (rst) begin
      q_c2h.delete();
      q_h2c.delete();
      m_resync = 1'b1;
      m_wait   = 1'b0;
      m_ack    = 1'b0;
      m_req    = 1'b0;
      m_pres   = 8'h00;
    end else begin
      nc = q_c2h.size();
      nh = q_h2c.size();
      if (nc > 0 && c2h_ready) void'(q_c2h.pop_front());
      if (m_resync) begin
        m_ack    = cpu_out[8];
        m_req    = cpu_out[12];
        m_resync = 1'b0;
      end else begin
        if (cpu_out[8] != m_ack && nc < DEPTH) begin
          q_c2h.push_back(cpu_out[7:0]);
          m_ack = cpu_out[8];
        end
        if (!m_wait) begin
          if (nh > 0) begin
            m_pres = q_h2c.pop_front();
            m_req  = !m_req;
            m_wait = 1'b1;
          end
        end else if (cpu_out[12] == m_req) begin
          if (nh > 0) begin
            m_pres = q_h2c.pop_front();
            m_req  = !m_req;
          end else begin
            m_wait = 1'b0;
          end
        end
      end
      if (h2c_valid && nh < DEPTH) q_h2c.push_back(h2c_data);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("cpu_in", cpu_in,
        {14'b0, m_wait, (q_c2h.size() == DEPTH), 3'b0, m_req, 3'b0, m_ack, m_pres});
    chk("c2h_valid", {31'b0, c2h_valid}, {31'b0, (q_c2h.size() > 0)});
    chk("h2c_ready", {31'b0, h2c_ready}, {31'b0, (q_h2c.size() < DEPTH)});
    if (q_c2h.size() > 0) chk("c2h_data", {24'b0, c2h_data}, {24'b0, q_c2h[0]});
  end

  // ---------------- stimulus ----------------
  logic tog;
  int   w;

  initial begin
    rst       = 1'b1;
    cpu_out   = 32'h0000_1100;
    c2h_ready = 1'b0;
    h2c_valid = 1'b0;
    h2c_data  = 8'h00;
    tog       = 1'b1;

    // 1. reset with stale toggles set, then RESYNC adopts them
    repeat (3) @(negedge clk);
    chk("rst_cpu_in", cpu_in, 32'h0);
    chk("rst_c2h_valid", {31'b0, c2h_valid}, 32'd0);
    chk("rst_h2c_ready", {31'b0, h2c_ready}, 32'd1);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("resync_cpu_in", cpu_in, 32'h0000_1100);
    chk("resync_c2h_valid", {31'b0, c2h_valid}, 32'd0);

    // 2. single byte CPU->host
    #1 cpu_out = 32'h0000_105A; tog = 1'b0;
    @(negedge clk);
    chk("t2_valid", {31'b0, c2h_valid}, 32'd1);
    chk("t2_data", {24'b0, c2h_data}, 32'h5A);
    chk("t2_ack", {31'b0, cpu_in[8]}, 32'd0);
    #1 c2h_ready = 1'b1;
    @(negedge clk);
    #1 c2h_ready = 1'b0;
    chk("t2_drained", {31'b0, c2h_valid}, 32'd0);

    // 3. five bytes into a 4-deep FIFO with the host stalled
    for (int i = 1; i <= 5; i++) begin
      #1 tog = ~tog;
      cpu_out = 32'h0000_1000;
      cpu_out[8] = tog;
      cpu_out[7:0] = 8'(i);
      @(negedge clk);
      if (i <= 4) chk("t3_ack", {31'b0, cpu_in[8]}, {31'b0, tog});
    end
    repeat (2) @(negedge clk);
    chk("t3_withheld", {31'b0, cpu_in[8]}, {31'b0, ~tog});
    chk("t3_full", {31'b0, cpu_in[16]}, 32'd1);
    #1 c2h_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      w = 0;
      while (!c2h_valid && w < 10) begin @(negedge clk); #1; w++; end
      chk("t3_order", {24'b0, c2h_data}, k);
      @(negedge clk); #1;
    end
    c2h_ready = 1'b0;
    chk("t3_empty", {31'b0, c2h_valid}, 32'd0);
    chk("t3_ack5", {31'b0, cpu_in[8]}, {31'b0, tog});

    // 4. host->CPU two bytes back to back (h2c_req is 1 after RESYNC)
    h2c_valid = 1'b1; h2c_data = 8'h12;
    @(negedge clk);
    #1 h2c_data = 8'h34;
    @(negedge clk);
    chk("t4_byte0", {24'b0, cpu_in[7:0]}, 32'h12);
    chk("t4_req0", {31'b0, cpu_in[12]}, 32'd0);
    chk("t4_pend0", {31'b0, cpu_in[17]}, 32'd1);
    #1 h2c_valid = 1'b0; cpu_out[12] = 1'b0;
    @(negedge clk);
    chk("t4_byte1", {24'b0, cpu_in[7:0]}, 32'h34);
    chk("t4_req1", {31'b0, cpu_in[12]}, 32'd1);
    #1 cpu_out[12] = 1'b1;
    @(negedge clk);
    chk("t4_idle", {31'b0, cpu_in[17]}, 32'd0);
    chk("t4_keep", {24'b0, cpu_in[7:0]}, 32'h34);

    // 5. fill h2c while the CPU sits on the first byte
    for (int i = 0; i < 5; i++) begin
      #1 h2c_valid = 1'b1; h2c_data = 8'hA0 + 8'(i);
      @(negedge clk);
    end
    chk("t5_full", {31'b0, h2c_ready}, 32'd0);
    chk("t5_pres", {24'b0, cpu_in[7:0]}, 32'hA0);
    #1 h2c_data = 8'hA5; cpu_out[12] = cpu_in[12];
    @(negedge clk);
    chk("t5_pop_nopush", {24'b0, cpu_in[7:0]}, 32'hA1);
    chk("t5_room", {31'b0, h2c_ready}, 32'd1);
    #1 cpu_out[12] = cpu_in[12];
    @(negedge clk);
    chk("t5_pop_push", {24'b0, cpu_in[7:0]}, 32'hA2);
    #1 h2c_valid = 1'b0;
    for (int j = 3; j <= 5; j++) begin
      cpu_out[12] = cpu_in[12];
      @(negedge clk);
      chk("t5_seq", {24'b0, cpu_in[7:0]}, 32'hA0 + j);
      #1;
    end
    cpu_out[12] = cpu_in[12];
    @(negedge clk);
    chk("t5_done", {31'b0, cpu_in[17]}, 32'd0);

    // 6. reset mid-transfer
    #1 tog = ~tog; cpu_out[8] = tog; cpu_out[7:0] = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      h2c_valid = 1'b1; h2c_data = 8'hB0 + 8'(i);
      @(negedge clk); #1;
    end
    h2c_valid = 1'b0;
    chk("t6_pre_pend", {31'b0, cpu_in[17]}, 32'd1);
    chk("t6_pre_valid", {31'b0, c2h_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_async_cpu_in", cpu_in, 32'h0);
    chk("t6_async_valid", {31'b0, c2h_valid}, 32'd0);
    chk("t6_async_ready", {31'b0, h2c_ready}, 32'd1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_resync_ack", {31'b0, cpu_in[8]}, {31'b0, tog});
    chk("t6_resync_req", {31'b0, cpu_in[12]}, {31'b0, cpu_out[12]});
    chk("t6_no_spurious", {31'b0, c2h_valid}, 32'd0);
    #1 tog = ~tog; cpu_out[8] = tog; cpu_out[7:0] = 8'h77;
    h2c_valid = 1'b1; h2c_data = 8'h88;
    @(negedge clk);
    chk("t6_c2h", {24'b0, c2h_data}, 32'h77);
    #1 h2c_valid = 1'b0;
    @(negedge clk);
    chk("t6_h2c", {24'b0, cpu_in[7:0]}, 32'h88);
    chk("t6_h2c_pend", {31'b0, cpu_in[17]}, 32'd1);

    // randomized traffic, firmware-like CPU behaviour, one mid-run reset
    for (int n = 0; n < 3000; n++) begin
      #1;
      if (n == 1500) rst = 1'b1;
      if (n == 1502) rst = 1'b0;
      c2h_ready = ($urandom_range(0, 3) != 0);
      h2c_valid = $urandom_range(0, 1);
      h2c_data  = 8'($urandom);
      cpu_out[31:13] = 19'($urandom);
      cpu_out[11:9]  = 3'($urandom);
      if (cpu_in[8] == tog && $urandom_range(0, 2) == 0) begin
        tog = ~tog;
        cpu_out[7:0] = 8'($urandom);
        cpu_out[8] = tog;
      end
      if (cpu_in[17] && cpu_in[12] != cpu_out[12]) begin
        if ($urandom_range(0, 1) == 1) cpu_out[12] = cpu_in[12];
      end else if (!cpu_in[17] && $urandom_range(0, 7) == 0) begin
        cpu_out[12] = ~cpu_out[12];
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
